// File: rtl/limn2600_mem_pkg.sv
// Shared definitions for the Limn2600 SRAM arbiter: FSM state encoding,
// requester port indices, the command payload presented to the SRAM and
// a word-alignment helper.
package limn2600_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    // Flat state constants; state registers are plain logic [1:0].
    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_ACCESS  = 2'(ACCESS);
    localparam logic [1:0] ST_RECOVER = 2'(RECOVER);

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DP = 1'b1;

    localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // One SRAM word command as latched from the granted requester.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // True when the byte address does not point at a word boundary.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr & ~WORD_ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/limn2600_rr_pick.sv
// Two-way round-robin pick.
// Ports:
//   req[1:0]       request vector, indexed by PORT_IF / PORT_DP
//   last_grant     port granted most recently
//   grant_valid_c  at least one request is pending (combinational)
//   grant_c        port to grant this cycle (combinational)
module limn2600_rr_pick
    import limn2600_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid_c,
    output logic       grant_c
);

    // A tie goes to whichever port was not served last.
    always_comb begin : pick
        grant_valid_c = |req;
        grant_c       = PORT_IF;
        if (req[PORT_DP] && req[PORT_IF]) begin
            grant_c = ~last_grant;
        end else if (req[PORT_DP]) begin
            grant_c = PORT_DP;
        end
    end

endmodule

// File: rtl/limn2600_sram_arbiter.sv
// Arbitrates the single-ported limn2600 SRAM between instruction fetch (IF,
// read-only) and load/store (DP, read/write). One word access at a time;
// each request is answered with a one-cycle ack carrying read data or error.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   if_req/if_addr            IF request and byte address
//   if_ack/if_rdata/if_err    IF completion pulse, read data, error
//   dp_req/dp_we/dp_addr/dp_wdata  DP request, write enable, address, data
//   dp_ack/dp_rdata/dp_err    DP completion pulse, read data, error
//   mem_cs/mem_we/mem_addr/mem_wdata  SRAM command
//   mem_rdy/mem_rdata         SRAM ready and read data
module limn2600_sram_arbiter
    import limn2600_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TCNT_W         = 5
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_ack,
    output logic [DATA_W-1:0] dp_rdata,
    output logic              dp_err,

    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state,      state_d;
    logic              owner,      owner_d;
    logic              last_grant, last_grant_d;
    logic [TCNT_W-1:0] tcnt,       tcnt_d;

    logic              mem_cs_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              if_ack_d, if_err_d, dp_ack_d, dp_err_d;
    logic [DATA_W-1:0] if_rdata_d, dp_rdata_d;

    logic              grant_valid_c;
    logic              grant_c;
    mem_cmd_t          sel_cmd_c;

    logic              rsp_ack_c;
    logic              rsp_err_c;
    logic              rsp_port_c;
    logic [DATA_W-1:0] rsp_rdata_c;

    limn2600_rr_pick u_rr_pick (
        .req           ({dp_req, if_req}),
        .last_grant    (last_grant),
        .grant_valid_c (grant_valid_c),
        .grant_c       (grant_c)
    );

    // Command of the port being granted; IF never writes.
    always_comb begin : cmd_mux
        sel_cmd_c.we    = 1'b0;
        sel_cmd_c.addr  = if_addr;
        sel_cmd_c.wdata = '0;
        if (grant_c == PORT_DP) begin
            sel_cmd_c.we    = dp_we;
            sel_cmd_c.addr  = dp_addr;
            sel_cmd_c.wdata = dp_wdata;
        end
    end

    // Next-state and next-output logic.
    always_comb begin : next_logic
        state_d      = state;
        owner_d      = owner;
        last_grant_d = last_grant;
        tcnt_d       = tcnt;
        mem_cs_d     = mem_cs;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = '0;
        dp_ack_d     = 1'b0;
        dp_err_d     = 1'b0;
        dp_rdata_d   = '0;
        rsp_ack_c    = 1'b0;
        rsp_err_c    = 1'b0;
        rsp_port_c   = owner;
        rsp_rdata_c  = '0;

        case (state)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    owner_d      = grant_c;
                    last_grant_d = grant_c;
                    if (is_misaligned(sel_cmd_c.addr)) begin
                        // Rejected without touching the SRAM.
                        rsp_ack_c  = 1'b1;
                        rsp_err_c  = 1'b1;
                        rsp_port_c = grant_c;
                        state_d    = ST_RECOVER;
                    end else begin
                        mem_cs_d    = 1'b1;
                        mem_we_d    = sel_cmd_c.we;
                        mem_addr_d  = sel_cmd_c.addr & WORD_ALIGN_MASK;
                        mem_wdata_d = sel_cmd_c.wdata;
                        tcnt_d      = '0;
                        state_d     = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_rdy) begin
                    rsp_ack_c   = 1'b1;
                    rsp_rdata_c = mem_rdata;
                    mem_cs_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    state_d     = ST_RECOVER;
                end else if (tcnt == TCNT_LAST) begin
                    rsp_ack_c = 1'b1;
                    rsp_err_c = 1'b1;
                    mem_cs_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_RECOVER;
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
            end

            // SRAM sees cs one edge late, so rdy lingers a cycle after cs drops.
            ST_RECOVER: begin
                if (!mem_rdy) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Route the single response to its owner.
        if (rsp_ack_c) begin
            if (rsp_port_c == PORT_DP) begin
                dp_ack_d   = 1'b1;
                dp_err_d   = rsp_err_c;
                dp_rdata_d = rsp_rdata_c;
            end else begin
                if_ack_d   = 1'b1;
                if_err_d   = rsp_err_c;
                if_rdata_d = rsp_rdata_c;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin : regs
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= PORT_IF;
            last_grant <= PORT_IF;
            tcnt       <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            dp_ack     <= 1'b0;
            dp_err     <= 1'b0;
            dp_rdata   <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_grant <= last_grant_d;
            tcnt       <= tcnt_d;
            mem_cs     <= mem_cs_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            if_ack     <= if_ack_d;
            if_err     <= if_err_d;
            if_rdata   <= if_rdata_d;
            dp_ack     <= dp_ack_d;
            dp_err     <= dp_err_d;
            dp_rdata   <= dp_rdata_d;
        end
    end

endmodule
